// File: rtl/countdown_sched_pkg.sv
// Shared types and default sizing for the countdown scheduler.
// The counter is owned by one requester at a time and walks it through LOAD -> COUNT -> DONE.
package countdown_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] din,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en && (q != '0)) begin
            q <= q - CW'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/countdown_sched.sv
// Round-robin arbiter plus FSM that lends a single saturating down-counter to NREQ requesters.
module countdown_sched
    import countdown_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]  grant,
    output logic [CW-1:0]    q,
    output logic             busy,
    output logic [NREQ-1:0]  done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [IW-1:0]   own_idx, own_n;
    logic [IW-1:0]   last_idx, last_n;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            owner_req;
    logic [CW-1:0]   owner_len;
    logic            cnt_load, cnt_en, cnt_zero;

    assign owner_req = req[own_idx];
    assign owner_len = len[own_idx*CW +: CW];

    // Search starts just above the last owner so every requester eventually gets a turn.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(last_idx) + 1 + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last_idx) + 1 + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            own_idx  <= '0;
            last_idx <= IW'(NREQ - 1);
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            own_idx  <= own_n;
            last_idx <= last_n;
        end
    end

    // Dropping the owner's request in LOAD or COUNT releases the counter without a done pulse.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        own_n    = own_idx;
        last_n   = last_idx;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (win_found) begin
                    grant_n = NREQ'(1) << win_idx;
                    own_n   = win_idx;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    state_n = IDLE;
                    grant_n = '0;
                    last_n  = own_idx;
                end else begin
                    cnt_load = 1'b1;
                    state_n  = COUNT;
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    state_n = IDLE;
                    grant_n = '0;
                    last_n  = own_idx;
                end else if (cnt_zero) begin
                    state_n = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                last_n  = own_idx;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) ? grant : '0;

    down_counter #(.CW(CW)) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .din  (owner_len),
        .en   (cnt_en),
        .q    (q),
        .zero (cnt_zero)
    );

endmodule

// File: tb/tb_countdown_sched.sv
// Directed self-checking bench for countdown_sched with hand-computed expectations.
module tb_countdown_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  q;
    logic        busy;
    logic [3:0]  done;

    int testsRun    = 0;
    int testsFailed = 0;

    countdown_sched #(.NREQ(4), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] ln);
        rst = r;
        req = rq;
        len = ln;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        applyStimulus(1'b1, 4'b0000, 16'h0000);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 4'b0000, 16'h0000);
        stepCycle();
    endtask

    initial begin
        logic [3:0] expGrant;
        logic [3:0] expDone;

        // Reset with every request pending
        applyStimulus(1'b1, 4'b1111, 16'h0000);
        stepCycle();
        stepCycle();
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_q",     32'(q),     32'h0);
        checkOutput("rst_busy",  32'(busy),  32'h0);
        checkOutput("rst_done",  32'(done),  32'h0);
        applyStimulus(1'b0, 4'b1111, 16'h0000);
        stepCycle();
        checkOutput("first_grant", 32'(grant), 32'h1);
        checkOutput("first_busy",  32'(busy),  32'h1);
        applyReset();

        // Single requester 2 with load value 3
        applyStimulus(1'b0, 4'b0100, 16'h0300);
        for (int c = 0; c < 8; c++) begin
            stepCycle();
            expGrant = (c < 6) ? 4'b0100 : 4'b0000;
            expDone  = (c == 5) ? 4'b0100 : 4'b0000;
            checkOutput($sformatf("len3_grant_c%0d", c), 32'(grant), 32'(expGrant));
            checkOutput($sformatf("len3_done_c%0d", c),  32'(done),  32'(expDone));
            if (c >= 1 && c <= 4)
                checkOutput($sformatf("len3_q_c%0d", c), 32'(q), 32'(4 - c));
            if (c == 5)
                applyStimulus(1'b0, 4'b0000, 16'h0300);
        end
        checkOutput("len3_idle_busy", 32'(busy), 32'h0);

        // Zero-length load still holds the grant for three cycles
        applyStimulus(1'b0, 4'b0001, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            expGrant = (c < 3) ? 4'b0001 : 4'b0000;
            expDone  = (c == 2) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("len0_grant_c%0d", c), 32'(grant), 32'(expGrant));
            checkOutput($sformatf("len0_done_c%0d", c),  32'(done),  32'(expDone));
            checkOutput($sformatf("len0_q_c%0d", c),     32'(q),     32'h0);
            if (c == 2)
                applyStimulus(1'b0, 4'b0000, 16'h0000);
        end
        applyReset();

        // All requesters held, len 1 each: 4 granted cycles then 1 idle per turn
        applyStimulus(1'b0, 4'b1111, 16'h1111);
        for (int c = 0; c < 24; c++) begin
            stepCycle();
            expGrant = ((c % 5) == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
            expDone  = ((c % 5) == 3) ? expGrant : 4'b0000;
            checkOutput($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(expGrant));
            checkOutput($sformatf("rr_done_c%0d", c),  32'(done),  32'(expDone));
        end
        applyReset();

        // Requester 1 aborts at q = 2; index 2 must win next over index 0
        applyStimulus(1'b0, 4'b0010, 16'h0050);
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput($sformatf("abort_grant_c%0d", c), 32'(grant), 32'h2);
            if (c >= 1)
                checkOutput($sformatf("abort_q_c%0d", c), 32'(q), 32'(6 - c));
        end
        applyStimulus(1'b0, 4'b0101, 16'h0050);
        stepCycle();
        checkOutput("abort_grant_off", 32'(grant), 32'h0);
        checkOutput("abort_q_hold",    32'(q),     32'h2);
        checkOutput("abort_no_done",   32'(done),  32'h0);
        checkOutput("abort_busy",      32'(busy),  32'h0);
        stepCycle();
        checkOutput("abort_next_grant", 32'(grant), 32'h4);
        checkOutput("abort_q_load",     32'(q),     32'h2);
        applyReset();

        // Reset in the middle of COUNT
        applyStimulus(1'b0, 4'b0001, 16'h0006);
        for (int c = 0; c < 4; c++)
            stepCycle();
        checkOutput("midrst_q_before", 32'(q), 32'h4);
        applyStimulus(1'b1, 4'b1111, 16'h0006);
        stepCycle();
        checkOutput("midrst_grant", 32'(grant), 32'h0);
        checkOutput("midrst_q",     32'(q),     32'h0);
        checkOutput("midrst_busy",  32'(busy),  32'h0);
        checkOutput("midrst_done",  32'(done),  32'h0);
        applyStimulus(1'b0, 4'b1111, 16'h0006);
        stepCycle();
        checkOutput("midrst_next_grant", 32'(grant), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/countdown_sched.md
COUNTDOWN_SCHED -- requirements
Module: countdown_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the down-counter.
REQ-002 Parameter CW, default 4: counter width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  NREQ  per-requester countdown request, level-held until done or abort.
REQ-006 Port len  input  NREQ*CW  per-requester load value; slice i = len[i*CW +: CW].
REQ-007 Port grant  output  NREQ  one-hot owner of the counter; all-zero when idle.
REQ-008 Port q  output  CW  current counter value.
REQ-009 Port busy  output  1  high whenever state != IDLE.
REQ-010 Port done  output  NREQ  one-cycle completion pulse to the owner.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, COUNT and DONE.
REQ-012 IDLE: if any req bit is high, the block SHALL select a winner by round-robin, register grant as one-hot of the winner and go to LOAD; otherwise it SHALL stay in IDLE with grant = 0.
REQ-013 Round-robin priority SHALL start at (last granted index + 1) mod NREQ and wrap upward; after reset, index 0 SHALL be highest.
REQ-014 LOAD: q SHALL be loaded with len[g] of the owner g in this cycle only; later len changes SHALL be ignored. Next state: COUNT.
REQ-015 COUNT: if q != 0, q SHALL decrement by 1; if q == 0, next state SHALL be DONE and q SHALL hold at 0.
REQ-016 Decrement SHALL never wrap below 0.
REQ-017 DONE: done[g] SHALL be high for exactly this cycle; grant SHALL stay high; next state SHALL be IDLE.
REQ-018 For load value L, grant SHALL be high for exactly L+3 cycles (1 LOAD, L+1 COUNT, 1 DONE); L = 0 SHALL give 3 cycles.
REQ-019 At least one IDLE cycle with grant = 0 SHALL separate consecutive grants.
REQ-020 Abort: if req[g] is low in LOAD or COUNT, the next state SHALL be IDLE and grant SHALL be 0 next cycle; done SHALL NOT pulse and q SHALL hold its value.
REQ-021 The last-granted pointer SHALL update on DONE and on abort alike.
REQ-022 Req bits of non-owners SHALL have no effect outside IDLE.
REQ-023 grant SHALL never have more than one bit set, and done SHALL only pulse on a bit that is also set in grant.

Reset
REQ-024 While rst is high at a clock edge: state SHALL be IDLE, grant = 0, done = 0, q = 0, busy = 0, and the pointer SHALL make index 0 highest priority.
REQ-025 Reset SHALL override every state, including mid-COUNT, in the same edge, with no done pulse.

Structure
REQ-026 Package countdown_sched_pkg SHALL hold the state enum typedef and the default NREQ/CW constants.
REQ-027 Sub-module down_counter (clk, rst, load, din, en, q, zero) SHALL implement the loadable saturating down-counter; the FSM and arbiter SHALL be in countdown_sched.

Verification
REQ-028 Reset with req = 4'b1111 for 2 cycles -> grant = 0, q = 0, busy = 0, done = 0; first grant after release = 4'b0001.
REQ-029 Only req[2], len[2] = 3 -> grant = 4'b0100 for 6 cycles; q = 3, 2, 1, 0 in COUNT; done = 4'b0100 in the 6th cycle only.
REQ-030 Only req[0], len[0] = 0 -> grant high 3 cycles, done[0] pulses once, q = 0 throughout.
REQ-031 req = 4'b1111 held, all len = 1 -> grant order 0001, 0010, 0100, 1000, 0001; each grant 4 cycles with 1 idle cycle between.
REQ-032 req[1] owner, len = 5, req[1] dropped when q = 2 -> grant = 0 next cycle, q holds 2, no done; next grant goes to index 2 when pending.
REQ-033 rst asserted during COUNT with q = 4 -> next cycle IDLE, all outputs 0, no done; index 0 wins the next arbitration.
